char_scroller: RTL and testbench

Sequential driver for the four-digit HEX display path on the DE1 lab board. It holds four 2-bit character codes and rotates them one position per prescaled time step, left or right. Each digit's code feeds one seven_segment decoder. The block replaces the manual switch-driven rotation select with a timed producer of the same four character streams.

---
 rtl/char_scroller.sv | 105 ++++++++++
 tb/tb_char_scroller.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/char_scroller.sv
// char_scroller: timed rotator for four 2-bit HEX character codes.
// Loads a word on a rising load edge and rotates one digit per tick.
module char_scroller #(
   parameter int TICK_DIV = 50000000
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic [7:0] word,
   input  logic       load,
   input  logic       run,
   input  logic       dir,
   output logic [1:0] char3,
   output logic [1:0] char2,
   output logic [1:0] char1,
   output logic [1:0] char0,
   output logic [1:0] pos,
   output logic       step
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

   typedef enum logic {
      HOLD   = 1'b0,
      SCROLL = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic [7:0]    disp_q, disp_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    pos_q, pos_d;
   logic          step_q, step_d;
   logic          load_q, load_d;

   logic load_ev;
   logic cnt_en;
   logic at_term;

   // Mode register: records whether the last edge was a scrolling one.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) state_q <= HOLD;
      else         state_q <= state_d;
   end

   // Next mode follows run; the edge being taken already counts in it.
   always_comb begin
      state_d = HOLD;
      if (run) state_d = SCROLL;
   end

   // Datapath actions for this edge; a load beats a rotation.
   always_comb begin
      disp_d  = disp_q;
      cnt_d   = cnt_q;
      pos_d   = pos_q;
      step_d  = 1'b0;
      load_d  = load;
      load_ev = load & ~load_q;
      cnt_en  = (state_d == SCROLL);
      at_term = cnt_en && (cnt_q == TERM);
      if (load_ev) begin
         disp_d = word;
         cnt_d  = '0;
         pos_d  = 2'd0;
      end else if (at_term) begin
         cnt_d  = '0;
         step_d = 1'b1;
         if (dir) begin
            disp_d = {disp_q[1:0], disp_q[7:2]};
            pos_d  = pos_q - 2'd1;
         end else begin
            disp_d = {disp_q[5:0], disp_q[7:6]};
            pos_d  = pos_q + 2'd1;
         end
      end else if (cnt_en) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Display, prescaler, offset, step pulse and load history.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         disp_q <= 8'h00;
         cnt_q  <= '0;
         pos_q  <= 2'd0;
         step_q <= 1'b0;
         load_q <= 1'b0;
      end else begin
         disp_q <= disp_d;
         cnt_q  <= cnt_d;
         pos_q  <= pos_d;
         step_q <= step_d;
         load_q <= load_d;
      end
   end

   assign char3 = disp_q[7:6];
   assign char2 = disp_q[5:4];
   assign char1 = disp_q[3:2];
   assign char0 = disp_q[1:0];
   assign pos   = pos_q;
   assign step  = step_q & (state_q == SCROLL);

endmodule

// File: tb/tb_char_scroller.sv
// tb_char_scroller: directed stimulus, per-cycle model compare,
// plus literal expectations for the key scenarios.
module tb_char_scroller;

   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [7:0] word = 8'h00;
   logic       load = 1'b0;
   logic       run = 1'b0;
   logic       dir = 1'b0;
   logic [1:0] char3, char2, char1, char0, pos;
   logic       step;

   int n_cmp = 0;
   int n_bad = 0;

   char_scroller #(.TICK_DIV(TD)) dut (
      .CLOCK_50(clk),
      .resetn(resetn),
      .word(word),
      .load(load),
      .run(run),
      .dir(dir),
      .char3(char3),
      .char2(char2),
      .char1(char1),
      .char0(char0),
      .pos(pos),
      .step(step)
   );

   always #5 clk = ~clk;

   // Model: loaded digits, net rotation count, scroll edges in interval.
   int m_w[4];
   int m_r;
   int m_el;
   bit m_step;
   bit m_pl;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int k = 0; k < 4; k++) m_w[k] = 0;
         m_r = 0;
         m_el = 0;
         m_step = 0;
         m_pl = 0;
      end else begin
         bit ev;
         ev = load && !m_pl;
         m_pl = load;
         m_step = 0;
         if (ev) begin
            for (int k = 0; k < 4; k++) m_w[k] = int'(word[2*k +: 2]);
            m_r = 0;
            m_el = 0;
         end else if (run) begin
            m_el++;
            if (m_el == TD) begin
               m_el = 0;
               m_r = dir ? m_r - 1 : m_r + 1;
               m_step = 1;
            end
         end
      end
   end

   function automatic int exp_char(int k);
      return m_w[(k - m_r) & 3];
   endfunction

   task automatic check(string name, int got, int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (resetn) begin
         check("m_char3", int'(char3), exp_char(3));
         check("m_char2", int'(char2), exp_char(2));
         check("m_char1", int'(char1), exp_char(1));
         check("m_char0", int'(char0), exp_char(0));
         check("m_pos", int'(pos), m_r & 3);
         check("m_step", int'(step), int'(m_step));
      end
   end

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic lit(string name, int c3, int c2, int c1, int c0, int p, int s);
      check({name, "_c3"}, int'(char3), c3);
      check({name, "_c2"}, int'(char2), c2);
      check({name, "_c1"}, int'(char1), c1);
      check({name, "_c0"}, int'(char0), c0);
      check({name, "_pos"}, int'(pos), p);
      check({name, "_step"}, int'(step), s);
   endtask

   task automatic do_load(logic [7:0] w, logic r, logic d);
      load = 1'b0;
      edge1();
      word = w;
      run = r;
      dir = d;
      load = 1'b1;
      edge1();
      load = 1'b0;
   endtask

   initial begin
      repeat (3) edge1();
      lit("rst_hold", 0, 0, 0, 0, 0, 0);
      resetn = 1'b1;
      edge1();
      lit("after_rst", 0, 0, 0, 0, 0, 0);

      // left rotation
      do_load(8'hE4, 1'b1, 1'b0);
      lit("l_load", 3, 2, 1, 0, 0, 0);
      for (int i = 1; i <= 4; i++) begin
         edge1();
         if (i < 4) check("l_nostep", int'(step), 0);
      end
      lit("l_step1", 2, 1, 0, 3, 1, 1);
      edge1();
      check("l_pulse1", int'(step), 0);
      repeat (11) edge1();
      lit("l_step4", 3, 2, 1, 0, 0, 1);

      // right rotation
      do_load(8'hE4, 1'b1, 1'b1);
      lit("r_load", 3, 2, 1, 0, 0, 0);
      repeat (4) edge1();
      lit("r_step1", 0, 3, 2, 1, 3, 1);
      repeat (4) edge1();
      lit("r_step2", 1, 0, 3, 2, 2, 1);

      // pause and resume
      do_load(8'hE4, 1'b1, 1'b0);
      repeat (2) edge1();
      run = 1'b0;
      for (int i = 0; i < 10; i++) begin
         edge1();
         check("p_hold", int'(step), 0);
      end
      run = 1'b1;
      edge1();
      check("p_res1", int'(step), 0);
      edge1();
      lit("p_res2", 2, 1, 0, 3, 1, 1);

      // load colliding with terminal count
      do_load(8'hE4, 1'b1, 1'b0);
      repeat (3) edge1();
      word = 8'h1B;
      load = 1'b1;
      edge1();
      lit("c_load", 0, 1, 2, 3, 0, 0);
      load = 1'b0;
      repeat (3) edge1();
      check("c_nostep", int'(step), 0);
      edge1();
      lit("c_step", 1, 2, 3, 0, 1, 1);

      // held load
      load = 1'b0;
      edge1();
      word = 8'hE4;
      dir = 1'b0;
      run = 1'b1;
      load = 1'b1;
      edge1();
      lit("h_load", 3, 2, 1, 0, 0, 0);
      repeat (20) edge1();
      lit("h_run", 2, 1, 0, 3, 1, 1);
      load = 1'b0;

      // async reset mid-run, while step is high
      do_load(8'hE4, 1'b1, 1'b0);
      repeat (4) edge1();
      check("a_pre_step", int'(step), 1);
      resetn = 1'b0;
      #1;
      lit("a_rst", 0, 0, 0, 0, 0, 0);
      word = 8'h1B;
      load = 1'b1;
      edge1();
      lit("a_rst_edge", 0, 0, 0, 0, 0, 0);
      resetn = 1'b1;
      edge1();
      lit("a_rel_load", 0, 1, 2, 3, 0, 0);
      load = 1'b0;
      repeat (6) edge1();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
